// File: rtl/selfcomp_leak_monitor.sv
// rtl/selfcomp_leak_monitor.sv - timing/result divergence monitor for two redundant SE copies
//
// Purpose: issues one instruction to two SE copies at once, then measures how
// many cycles each copy needs to complete and captures both results. Once both
// copies have completed or timed out, the monitor judges the transaction. Any
// difference raises sticky leak status.
//
// Ports:
//   clock, reset (async active-low), clear (sync clear of status/counters)
//   issue_valid / issue_ready         : issue handshake, ready only in IDLE
//   validOne/validTwo, resultOne/Two  : per-copy completion and 128-bit result
//   out_ready                         : consumer ready shared by both copies
//   lat_one/lat_two                   : latencies of the last judged transaction
//   done                              : one-cycle pulse in the REPORT cycle
//   leak, leak_cause[2:0]             : sticky {timeout, result, timing} causes
//   txn_count                         : judged transactions, wraps at 16 bits
module selfcomp_leak_monitor #(
  parameter int unsigned MAX_LAT      = 255,
  parameter bit          CHECK_RESULT = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         issue_valid,
  output logic         issue_ready,
  input  logic         validOne,
  input  logic         validTwo,
  input  logic [127:0] resultOne,
  input  logic [127:0] resultTwo,
  input  logic         out_ready,
  output logic [7:0]   lat_one,
  output logic [7:0]   lat_two,
  output logic         done,
  output logic         leak,
  output logic [2:0]   leak_cause,
  output logic [15:0]  txn_count
);

  localparam logic [7:0] MaxLat = 8'(MAX_LAT);

  // WAIT_ONE: copy two is done, still waiting for copy one; WAIT_TWO mirrors it.
  typedef enum logic [2:0] {IDLE, WAIT_BOTH, WAIT_ONE, WAIT_TWO, REPORT} state_e;

  state_e         state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [7:0]     cap_lat1_q, cap_lat1_d, cap_lat2_q, cap_lat2_d;
  logic [127:0]   res1_q, res1_d, res2_q, res2_d;
  logic [7:0]     lat1_q, lat1_d, lat2_q, lat2_d;
  logic           done_q, done_d;
  logic [2:0]     cause_q, cause_d;
  logic [15:0]    txn_q, txn_d;

  logic           fire, in_wait, need1, need2, comp1, comp2, miss1, miss2;
  logic           timeout, finish;
  logic [7:0]     fin_lat1, fin_lat2;
  logic [127:0]   fin_res1, fin_res2;
  logic [2:0]     new_cause;

  assign fire    = issue_valid && (state_q == IDLE);
  assign in_wait = state_q inside {WAIT_BOTH, WAIT_ONE, WAIT_TWO};
  assign need1   = (state_q == WAIT_BOTH) || (state_q == WAIT_ONE);
  assign need2   = (state_q == WAIT_BOTH) || (state_q == WAIT_TWO);
  assign comp1   = need1 && validOne && out_ready;
  assign comp2   = need2 && validTwo && out_ready;
  assign miss1   = need1 && !comp1;
  assign miss2   = need2 && !comp2;
  assign timeout = in_wait && (cnt_q == MaxLat) && (miss1 || miss2);
  assign finish  = in_wait && ((!miss1 && !miss2) || timeout);

  // Final per-copy view for the judging edge: a copy completing this cycle uses
  // the live counter/result, a copy still missing at timeout reads MAX_LAT, and
  // a copy that finished earlier uses its captured values.
  assign fin_lat1 = comp1 ? cnt_q : (miss1 ? MaxLat : cap_lat1_q);
  assign fin_lat2 = comp2 ? cnt_q : (miss2 ? MaxLat : cap_lat2_q);
  assign fin_res1 = comp1 ? resultOne : res1_q;
  assign fin_res2 = comp2 ? resultTwo : res2_q;
  // Results are not compared after a timeout: one of them was never produced.
  assign new_cause = {timeout,
                      CHECK_RESULT && !timeout && (fin_res1 != fin_res2),
                      fin_lat1 != fin_lat2};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (fire) state_d = WAIT_BOTH;
      WAIT_BOTH: begin
        if (finish)     state_d = REPORT;
        else if (comp1) state_d = WAIT_TWO;
        else if (comp2) state_d = WAIT_ONE;
      end
      WAIT_ONE,
      WAIT_TWO:  if (finish) state_d = REPORT;
      REPORT:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (clear) state_d = IDLE;
  end

  // Output logic
  always_comb begin
    issue_ready = (state_q == IDLE);
  end

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    cap_lat1_d = cap_lat1_q;
    cap_lat2_d = cap_lat2_q;
    res1_d     = res1_q;
    res2_d     = res2_q;
    lat1_d     = lat1_q;
    lat2_d     = lat2_q;
    done_d     = 1'b0;
    cause_d    = cause_q;
    txn_d      = txn_q;
    if (clear) begin
      cnt_d   = 8'd0;
      lat1_d  = 8'd0;
      lat2_d  = 8'd0;
      cause_d = 3'd0;
      txn_d   = 16'd0;
    end else begin
      // Loading 1 on fire makes the counter read k in cycle fire+k.
      if (fire)         cnt_d = 8'd1;
      else if (in_wait) cnt_d = (cnt_q == MaxLat) ? cnt_q : cnt_q + 8'd1;
      else              cnt_d = 8'd0;
      if (comp1) begin
        cap_lat1_d = cnt_q;
        res1_d     = resultOne;
      end
      if (comp2) begin
        cap_lat2_d = cnt_q;
        res2_d     = resultTwo;
      end
      // Status updates on the edge entering REPORT so they are visible with done.
      if (finish) begin
        lat1_d  = fin_lat1;
        lat2_d  = fin_lat2;
        cause_d = cause_q | new_cause;
        txn_d   = txn_q + 16'd1;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= 8'd0;
      cap_lat1_q <= 8'd0;
      cap_lat2_q <= 8'd0;
      res1_q     <= 128'd0;
      res2_q     <= 128'd0;
      lat1_q     <= 8'd0;
      lat2_q     <= 8'd0;
      done_q     <= 1'b0;
      cause_q    <= 3'd0;
      txn_q      <= 16'd0;
    end else begin
      cnt_q      <= cnt_d;
      cap_lat1_q <= cap_lat1_d;
      cap_lat2_q <= cap_lat2_d;
      res1_q     <= res1_d;
      res2_q     <= res2_d;
      lat1_q     <= lat1_d;
      lat2_q     <= lat2_d;
      done_q     <= done_d;
      cause_q    <= cause_d;
      txn_q      <= txn_d;
    end
  end

  assign lat_one    = lat1_q;
  assign lat_two    = lat2_q;
  assign done       = done_q;
  assign leak_cause = cause_q;
  assign leak       = |cause_q;
  assign txn_count  = txn_q;

endmodule

// File: tb/tb_selfcomp_leak_monitor.sv
// tb/tb_selfcomp_leak_monitor.sv - self-checking bench for selfcomp_leak_monitor
module tb_selfcomp_leak_monitor;

  logic         clock = 1'b0;
  logic         rst_n, clear, issue_valid, validOne, validTwo, out_ready;
  logic [127:0] resultOne, resultTwo;

  logic         ready_w [3];
  logic [7:0]   lat1_w  [3];
  logic [7:0]   lat2_w  [3];
  logic         done_w  [3];
  logic         leak_w  [3];
  logic [2:0]   cause_w [3];
  logic [15:0]  txn_w   [3];

  always #5 clock = ~clock;

  selfcomp_leak_monitor dut0 (
    .clock(clock), .reset(rst_n), .clear(clear), .issue_valid(issue_valid),
    .issue_ready(ready_w[0]), .validOne(validOne), .validTwo(validTwo),
    .resultOne(resultOne), .resultTwo(resultTwo), .out_ready(out_ready),
    .lat_one(lat1_w[0]), .lat_two(lat2_w[0]), .done(done_w[0]), .leak(leak_w[0]),
    .leak_cause(cause_w[0]), .txn_count(txn_w[0]));

  selfcomp_leak_monitor #(.CHECK_RESULT(1'b0)) dut1 (
    .clock(clock), .reset(rst_n), .clear(clear), .issue_valid(issue_valid),
    .issue_ready(ready_w[1]), .validOne(validOne), .validTwo(validTwo),
    .resultOne(resultOne), .resultTwo(resultTwo), .out_ready(out_ready),
    .lat_one(lat1_w[1]), .lat_two(lat2_w[1]), .done(done_w[1]), .leak(leak_w[1]),
    .leak_cause(cause_w[1]), .txn_count(txn_w[1]));

  selfcomp_leak_monitor #(.MAX_LAT(8)) dut2 (
    .clock(clock), .reset(rst_n), .clear(clear), .issue_valid(issue_valid),
    .issue_ready(ready_w[2]), .validOne(validOne), .validTwo(validTwo),
    .resultOne(resultOne), .resultTwo(resultTwo), .out_ready(out_ready),
    .lat_one(lat1_w[2]), .lat_two(lat2_w[2]), .done(done_w[2]), .leak(leak_w[2]),
    .leak_cause(cause_w[2]), .txn_count(txn_w[2]));

  // Reference model parameters and sticky state, one entry per instance.
  int          maxl [3] = '{255, 255, 8};
  bit          crv  [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] mcount [3];
  logic [2:0]  mcause [3];

  // Per-transaction stimulus schedule, index = cycles after fire (0 = fire cycle).
  bit           sv1 [300];
  bit           sv2 [300];
  bit           sord [300];
  logic [127:0] sr1 [300];
  logic [127:0] sr2 [300];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int           f1;
    int           f2;
    logic [127:0] r1;
    logic [127:0] r2;
    int           l1;
    int           l2;
    logic [2:0]   cause;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int d, input logic [127:0] act,
                     input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, d, act, exp);
    end
  endtask

  // First cycle in 1..ml where the copy completes; 0 when it never does.
  function automatic int first_comp(input bit which, input int ml);
    for (int k = 1; k <= ml; k++)
      if ((which ? sv2[k] : sv1[k]) && sord[k]) return k;
    return 0;
  endfunction

  task automatic drive(input int k);
    validOne  = sv1[k];
    validTwo  = sv2[k];
    out_ready = sord[k];
    resultOne = sr1[k];
    resultTwo = sr2[k];
  endtask

  task automatic zero_model();
    for (int d = 0; d < 3; d++) begin
      mcount[d] = 16'd0;
      mcause[d] = 3'd0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    zero_model();
  endtask

  // Directed schedule: fire-cycle valids, completion at f, then stray later
  // valids carrying different data that must be ignored.
  task automatic build(input int f1, input int f2, input logic [127:0] r1,
                       input logic [127:0] r2);
    for (int k = 0; k < 300; k++) begin
      sord[k] = 1'b1;
      sv1[k]  = (k == 0) || (f1 != 0 && k >= f1 && k <= f1 + 3);
      sv2[k]  = (k == 0) || (f2 != 0 && k >= f2 && k <= f2 + 3);
      sr1[k]  = (k == f1) ? r1 : ~r1;
      sr2[k]  = (k == f2) ? r2 : ~r2;
    end
  endtask

  task automatic build_random();
    int           cut1, cut2;
    logic [127:0] base;
    cut1 = $urandom_range(0, 15);
    cut2 = $urandom_range(0, 15);
    base = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 300; k++) begin
      sv1[k]  = (k <= cut1) && ($urandom_range(0, 2) == 0);
      sv2[k]  = (k <= cut2) && ($urandom_range(0, 2) == 0);
      sord[k] = ($urandom_range(0, 3) != 0);
      sr1[k]  = ($urandom_range(0, 1) == 0) ? base : base ^ (128'd1 << $urandom_range(0, 127));
      sr2[k]  = ($urandom_range(0, 1) == 0) ? base : base ^ (128'd1 << $urandom_range(0, 127));
    end
  endtask

  // One transaction on all instances. With has_exp, instance 0 is judged
  // against the hand-written table values instead of the model.
  task automatic run_txn(input bit has_exp, input int e1, input int e2,
                         input logic [2:0] ec);
    int         dd [3];
    int         l1 [3];
    int         l2 [3];
    int         maxd;
    int         f1, f2;
    bit         to;
    logic [2:0] c;
    maxd = 0;
    for (int d = 0; d < 3; d++) begin
      f1 = first_comp(1'b0, maxl[d]);
      f2 = first_comp(1'b1, maxl[d]);
      to = (f1 == 0) || (f2 == 0);
      l1[d] = (f1 != 0) ? f1 : maxl[d];
      l2[d] = (f2 != 0) ? f2 : maxl[d];
      c = {to, crv[d] && !to && (sr1[f1] != sr2[f2]), l1[d] != l2[d]};
      dd[d] = (to ? maxl[d] : (f1 > f2 ? f1 : f2)) + 1;
      if (d == 0 && has_exp) begin
        l1[d] = e1;
        l2[d] = e2;
        c     = ec;
      end
      mcause[d] = mcause[d] | c;
      mcount[d] = mcount[d] + 16'd1;
      if (dd[d] > maxd) maxd = dd[d];
    end
    issue_valid = 1'b1;
    drive(0);
    @(posedge clock); #1;
    issue_valid = 1'b0;
    for (int k = 1; k <= maxd + 1; k++) begin
      for (int d = 0; d < 3; d++) begin
        chk("issue_ready", d, 128'(ready_w[d]), 128'(k > dd[d]));
        if (k == dd[d]) begin
          chk("done", d, 128'(done_w[d]), 128'd1);
          chk("lat_one", d, 128'(lat1_w[d]), 128'(l1[d]));
          chk("lat_two", d, 128'(lat2_w[d]), 128'(l2[d]));
          chk("leak_cause", d, 128'(cause_w[d]), 128'(mcause[d]));
          chk("leak", d, 128'(leak_w[d]), 128'(|mcause[d]));
          chk("txn_count", d, 128'(txn_w[d]), 128'(mcount[d]));
        end else begin
          chk("done_idle", d, 128'(done_w[d]), 128'd0);
        end
      end
      drive(k);
      @(posedge clock); #1;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_ready"}, d, 128'(ready_w[d]), 128'd1);
      chk({tag, "_done"},  d, 128'(done_w[d]),  128'd0);
      chk({tag, "_leak"},  d, 128'(leak_w[d]),  128'd0);
      chk({tag, "_cause"}, d, 128'(cause_w[d]), 128'd0);
      chk({tag, "_lat1"},  d, 128'(lat1_w[d]),  128'd0);
      chk({tag, "_lat2"},  d, 128'(lat2_w[d]),  128'd0);
      chk({tag, "_txn"},   d, 128'(txn_w[d]),   128'd0);
    end
  endtask

  initial begin
    tbl[0] = '{3,   3,   128'hA5, 128'hA5, 3,   3,   3'b000};
    tbl[1] = '{3,   5,   128'hA5, 128'hA5, 3,   5,   3'b001};
    tbl[2] = '{2,   2,   128'h1,  128'h2,  2,   2,   3'b010};
    tbl[3] = '{1,   1,   128'h7,  128'h7,  1,   1,   3'b000};
    tbl[4] = '{5,   2,   128'h7,  128'h9,  5,   2,   3'b011};
    tbl[5] = '{2,   0,   128'h3,  128'h3,  2,   255, 3'b101};
    tbl[6] = '{255, 255, 128'h4,  128'h4,  255, 255, 3'b000};
    tbl[7] = '{0,   0,   128'h0,  128'h0,  255, 255, 3'b100};

    rst_n = 1'b0; clear = 1'b0; issue_valid = 1'b0;
    validOne = 1'b0; validTwo = 1'b0; out_ready = 1'b0;
    resultOne = '0; resultTwo = '0;
    zero_model();
    repeat (3) @(posedge clock);
    #1;
    rst_n = 1'b1;
    chk_reset_state("rst");

    // Directed table, each entry judged from a cleared state.
    for (int i = 0; i < 8; i++) begin
      do_clear();
      build(tbl[i].f1, tbl[i].f2, tbl[i].r1, tbl[i].r2);
      run_txn(1'b1, tbl[i].l1, tbl[i].l2, tbl[i].cause);
    end
    do_clear();
    chk_reset_state("clear");

    // issue_valid held high with instant completions: one fire every 3 cycles.
    issue_valid = 1'b1; validOne = 1'b1; validTwo = 1'b1; out_ready = 1'b1;
    resultOne = '0; resultTwo = '0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clock); #1;
      chk("hold_done", 0, 128'(done_w[0]), 128'(e % 3 == 2));
      chk("hold_ready", 0, 128'(ready_w[0]), 128'(e % 3 == 0));
      if (e == 12) begin
        issue_valid = 1'b0; validOne = 1'b0; validTwo = 1'b0;
      end
    end
    for (int d = 0; d < 3; d++) chk("hold_txn", d, 128'(txn_w[d]), 128'd4);
    do_clear();

    // clear in the completing cycle wins over the judgement.
    issue_valid = 1'b1;
    @(posedge clock); #1;
    issue_valid = 1'b0; validOne = 1'b1; validTwo = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0; validOne = 1'b0; validTwo = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("clr_done", d, 128'(done_w[d]), 128'd0);
      chk("clr_ready", d, 128'(ready_w[d]), 128'd1);
      chk("clr_txn", d, 128'(txn_w[d]), 128'd0);
    end
    @(posedge clock); #1;
    chk("clr_after_done", 0, 128'(done_w[0]), 128'd0);

    // Randomized transactions against the model, sticky status accumulating.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      build_random();
      run_txn(1'b0, 0, 0, 3'b000);
    end

    // Reset in WAIT_BOTH abandons the transaction immediately.
    out_ready = 1'b1; validOne = 1'b0; validTwo = 1'b0; issue_valid = 1'b1;
    @(posedge clock); #1;
    issue_valid = 1'b0;
    @(posedge clock); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(posedge clock); #1;
    chk("midrst_done", 0, 128'(done_w[0]), 128'd0);
    rst_n = 1'b1;
    zero_model();
    // First fire right on the first edge after reset release.
    build(2, 2, 128'h5, 128'h5);
    run_txn(1'b1, 2, 2, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
